// File: rtl/carbonx96_simctl.sv
// CarbonX96 simulation-control peripheral: pass signature, console FIFO, cycle counter
// and poweroff sequencing that waits for the console to drain before ending the test.
module carbonx96_simctl #(
    parameter int unsigned CON_DEPTH    = 4,
    parameter logic [7:0]  POWEROFF_KEY = 8'hA5,
    parameter logic [31:0] SIG_RESET    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [7:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic        bus_ack,
    output logic [7:0]  bus_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic [31:0] signature,
    output logic        poweroff
);
    localparam int unsigned      PTR_W      = $clog2(CON_DEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CON_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_OFF} state_t;

    state_t           state;
    logic [7:0]       con_mem [CON_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] con_count;
    logic             overflow;
    logic [31:0]      cycles;
    logic [31:0]      cycles_shadow;
    logic [7:0]       rdata_next;

    logic access;
    logic rd_en;
    logic wr_en;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push_req;
    logic push;
    logic key_write;

    // A request is only taken while no ack is outstanding; OFF turns every write into a no-op.
    assign access     = bus_req && !bus_ack;
    assign rd_en      = access && !bus_we;
    assign wr_en      = access && bus_we && (state != ST_OFF);
    assign fifo_full  = (con_count == FULL_COUNT);
    assign fifo_empty = (con_count == '0);
    assign pop        = !fifo_empty && con_ready;
    assign push_req   = wr_en && (bus_addr == 8'h06);
    assign push       = push_req && (!fifo_full || pop);
    assign key_write  = wr_en && (state == ST_RUN) && (bus_addr == 8'h04)
                        && (bus_wdata == POWEROFF_KEY);
    assign con_valid  = !fifo_empty;
    assign con_data   = con_mem[rd_ptr];

    always_comb begin
        // NOTE: default first, so every path assigns rdata_next and no latch is inferred.
        rdata_next = '0;
        case (bus_addr)
            8'h00:   rdata_next = signature[7:0];
            8'h01:   rdata_next = signature[15:8];
            8'h02:   rdata_next = signature[23:16];
            8'h03:   rdata_next = signature[31:24];
            8'h05:   rdata_next = {4'b0000, overflow, fifo_empty, fifo_full, state != ST_RUN};
            8'h08:   rdata_next = cycles[7:0];
            8'h09:   rdata_next = cycles_shadow[15:8];
            8'h0A:   rdata_next = cycles_shadow[23:16];
            8'h0B:   rdata_next = cycles_shadow[31:24];
            default: rdata_next = '0;
        endcase
    end

    // NOTE: FIFO storage has no reset; con_valid gates con_data, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            con_mem[wr_ptr] <= bus_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
            state         <= ST_RUN;
            bus_ack       <= 1'b0;
            bus_rdata     <= '0;
            signature     <= SIG_RESET;
            poweroff      <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            con_count     <= '0;
            overflow      <= 1'b0;
            cycles        <= '0;
            cycles_shadow <= '0;
        end else begin
            bus_ack   <= access;
            bus_rdata <= rd_en ? rdata_next : '0;

            if (rd_en && (bus_addr == 8'h08)) begin
                cycles_shadow <= cycles;
            end
            if ((state != ST_OFF) && (cycles != '1)) begin
                cycles <= cycles + 32'd1;
            end

            if (wr_en && (state == ST_RUN) && (bus_addr[7:2] == 6'd0)) begin
                signature[{bus_addr[1:0], 3'b000} +: 8] <= bus_wdata;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   con_count <= con_count + 1'b1;
                2'b01:   con_count <= con_count - 1'b1;
                default: con_count <= con_count;
            endcase

            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (wr_en && (bus_addr == 8'h07)) begin
                overflow <= 1'b0;
            end

            poweroff <= (state == ST_OFF);

            // DRAIN ends on the first edge with an empty FIFO and no byte arriving.
            case (state)
                ST_RUN:   if (key_write) state <= ST_DRAIN;
                ST_DRAIN: if (fifo_empty && !push) state <= ST_OFF;
                default:  state <= state;
            endcase
        end
    end

endmodule
